decoder_scan_ctrl: RTL and testbench
====================================

Name: decoder_scan_ctrl

Overview:
Sequencer that sits directly upstream of decoder_3to8 and generates its 3-bit select input (sel_out drives the decoder's in). On a start command it steps sel_out through an address range from first_sel to last_sel, up or down, holding each address for a programmable dwell time. It then either finishes or wraps continuously. It adds a valid/busy/done/wrap status so downstream logic can gate the decoded one-hot output.

Parameters:
SEL_W, 3, width of the select bus; range wraps modulo 2^SEL_W.
DWELL_W, 8, width of dwell count; each address is held dwell+1 cycles.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin scan; sampled only in IDLE.
stop  input  1  abort scan; sampled only in RUN.
mode  input  2  mode[0]: 0 = count up, 1 = count down; mode[1]: 0 = single pass, 1 = continuous.
dwell  input  DWELL_W  hold time minus one, per address.
first_sel  input  SEL_W  first address of the range.
last_sel  input  SEL_W  last address of the range.
sel_out  output  SEL_W  select to decoder; registered.
sel_valid  output  1  sel_out is part of an active scan.
busy  output  1  state is RUN.
done  output  1  one-cycle pulse on normal completion of a single pass.
wrap_pulse  output  1  one-cycle pulse when a continuous scan reloads first_sel.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, sel_out = 0, sel_valid = 0, busy = 0, done = 0, wrap_pulse = 0, dwell counter = 0. Reset mid-scan aborts immediately; no done pulse.
- States: IDLE and RUN only. All outputs are registered.
- IDLE:
  - If start = 1 at an edge, capture mode, dwell, first_sel and last_sel into internal registers.
  - In the next cycle: sel_out = first_sel, sel_valid = 1, busy = 1, counter = 0, state = RUN.
  - Input changes after capture have no effect until the next start.
- RUN, per edge:
  - stop = 1 has priority over everything. Next cycle: state = IDLE, sel_valid = 0, busy = 0, done = 0, wrap_pulse = 0; sel_out holds its value.
  - Otherwise, if counter != dwell_q: counter increments.
  - Otherwise (counter == dwell_q), the dwell is complete and counter returns to 0. Then one of the following applies:
    - sel_out != last_sel: sel_out steps by +1 (up) or -1 (down), modulo 2^SEL_W (7 -> 0 up, 0 -> 7 down).
    - sel_out == last_sel and continuous: sel_out = first_sel and wrap_pulse = 1 for that one cycle.
    - sel_out == last_sel and single pass: state = IDLE, sel_valid = 0, busy = 0, done = 1 for one cycle; sel_out holds last_sel.
- Each address is therefore presented for exactly dwell_q+1 cycles. With dwell = 0, sel_out advances every cycle.
- Range direction is not checked. If first_sel > last_sel when counting up, the scan wraps through 2^SEL_W-1 -> 0 until it reaches last_sel. The down direction behaves symmetrically.
- first_sel == last_sel:
  - single pass: one address for dwell+1 cycles, then done.
  - continuous: the address stays constant, and wrap_pulse fires every dwell+1 cycles.
- start while busy is ignored. stop in IDLE is ignored. start and stop in the same IDLE cycle: start is accepted.
- start in the same cycle that done = 1 (state already IDLE) is accepted; the new scan begins the next cycle.
- done and wrap_pulse are never asserted together.

Test Plan:
- Reset, then start with mode = 00, dwell = 1, first = 0, last = 7 -> sel_out = 0,0,1,1,...,7,7 with sel_valid = 1 for 16 cycles; next cycle sel_valid = 0, busy = 0, done = 1 for one cycle; sel_out stays 7.
- mode = 01, dwell = 0, first = 1, last = 6 -> sel_out 1,0,7,6 on consecutive cycles (down wrap); done pulse on the 5th cycle.
- mode = 10, dwell = 0, first = 2, last = 4 -> 2,3,4,2,3,4,... with wrap_pulse = 1 exactly in the cycles where sel_out reloads to 2. Assert stop while sel_out = 3 -> next cycle sel_valid = 0, busy = 0, done = 0, sel_out = 3.
- First scan (mode 00, dwell 3, first = 5, last = 5): assert start again while busy with first = 0 -> ignored; sel_out = 5 for 4 cycles, then done. Same-cycle start with first = 0 -> new scan shows sel_out = 0 in the following cycle.
- Mid-scan rst_n low for a partial cycle (asynchronous) -> all outputs 0 immediately with no clock edge required; after release, start re-runs the scan correctly from first_sel.
- With a decoder_3to8 instance attached: out is one-hot 8'b00000001 << sel_out whenever sel_valid = 1, across a full up scan.

Source files
------------

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//   Generates the select input of a downstream 3-to-8 decoder. On start it
//   walks sel_out from first_sel to last_sel (up or down, modulo 2^SEL_W),
//   holding each address for dwell+1 cycles, then finishes or wraps.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : begin scan (sampled in IDLE only)
//   stop             : abort scan (sampled in RUN only)
//   mode[0]          : 0 = count up, 1 = count down
//   mode[1]          : 0 = single pass, 1 = continuous
//   dwell            : hold time minus one, per address
//   first_sel        : first address of the range
//   last_sel         : last address of the range
//   sel_out          : registered select to the decoder
//   sel_valid        : sel_out belongs to an active scan
//   busy             : scan in progress
//   done             : one-cycle pulse on single-pass completion
//   wrap_pulse       : one-cycle pulse when a continuous scan reloads first_sel
module decoder_scan_ctrl #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [SEL_W-1:0]   first_sel,
  input  logic [SEL_W-1:0]   last_sel,
  output logic [SEL_W-1:0]   sel_out,
  output logic               sel_valid,
  output logic               busy,
  output logic               done,
  output logic               wrap_pulse
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic [1:0]         mode_q;
  logic [SEL_W-1:0]   first_q;
  logic [SEL_W-1:0]   last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dwell_q    <= '0;
      mode_q     <= '0;
      first_q    <= '0;
      last_q     <= '0;
      sel_out    <= '0;
      sel_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      done       <= 1'b0;
      wrap_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            dwell_q   <= dwell;
            first_q   <= first_sel;
            last_q    <= last_sel;
            sel_out   <= first_sel;
            sel_valid <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state     <= IDLE;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (cnt != dwell_q) begin
            cnt <= cnt + DWELL_W'(1);
          end else begin
            cnt <= '0;
            if (sel_out != last_q) begin
              // Natural SEL_W-bit overflow gives the modulo wrap both ways.
              if (mode_q[0]) sel_out <= sel_out - SEL_W'(1);
              else           sel_out <= sel_out + SEL_W'(1);
            end else if (mode_q[1]) begin
              sel_out    <= first_q;
              wrap_pulse <= 1'b1;
            end else begin
              state     <= IDLE;
              sel_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
module tb_decoder_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [7:0] dwell;
  logic [2:0] first_sel;
  logic [2:0] last_sel;
  logic [2:0] sel_out;
  logic       sel_valid;
  logic       busy;
  logic       done;
  logic       wrap_pulse;

  int checks = 0;
  int errors = 0;

  decoder_scan_ctrl #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .dwell     (dwell),
    .first_sel (first_sel),
    .last_sel  (last_sel),
    .sel_out   (sel_out),
    .sel_valid (sel_valid),
    .busy      (busy),
    .done      (done),
    .wrap_pulse(wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic       valid;
    logic       busy;
    logic       done;
    logic       wrap;
  } exp_t;

  typedef struct {
    logic [1:0] m;
    int         d;
    logic [2:0] f;
    logic [2:0] l;
    int         ncyc;
    int         stop_at;
    int         exp_valid_cycles;
    logic [2:0] exp_end_sel;
  } vec_t;

  // Reference: expected outputs t cycles after the start edge, computed
  // from scan length and elapsed time rather than a cycle-stepped machine.
  function automatic exp_t model(logic [1:0] m, int d, logic [2:0] f, logic [2:0] l, int t);
    exp_t e;
    int per, len, k, idx;
    logic [2:0] kk;
    per = d + 1;
    len = m[0] ? ((int'(f) - int'(l)) & 7) + 1 : ((int'(l) - int'(f)) & 7) + 1;
    k   = t / per;
    e.done = 1'b0;
    e.wrap = 1'b0;
    if (!m[1]) begin
      idx = k;
      if (k < len) begin
        e.valid = 1'b1; e.busy = 1'b1;
      end else begin
        e.valid = 1'b0; e.busy = 1'b0;
        e.done  = (t == len * per);
        idx     = len - 1;
      end
    end else begin
      idx = k % len;
      e.valid = 1'b1; e.busy = 1'b1;
      e.wrap  = (t % per == 0) && (idx == 0) && (k > 0);
    end
    kk    = 3'(idx);
    e.sel = m[0] ? f - kk : f + kk;
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(string tag, exp_t e);
    chk({tag, ".sel_out"},    int'(sel_out),    int'(e.sel));
    chk({tag, ".sel_valid"},  int'(sel_valid),  int'(e.valid));
    chk({tag, ".busy"},       int'(busy),       int'(e.busy));
    chk({tag, ".done"},       int'(done),       int'(e.done));
    chk({tag, ".wrap_pulse"}, int'(wrap_pulse), int'(e.wrap));
  endtask

  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the DUT idle; afterwards the DUT shows t=0.
  task automatic start_scan(logic [1:0] m, int d, logic [2:0] f, logic [2:0] l);
    mode = m; dwell = 8'(d); first_sel = f; last_sel = l;
    start = 1'b1;
    step_clk();
    start = 1'b0;
    // Post-capture input changes must not matter.
    mode = 2'($urandom); dwell = 8'($urandom); first_sel = 3'($urandom); last_sel = 3'($urandom);
  endtask

  task automatic run_scan(string tag, logic [1:0] m, int d, logic [2:0] f, logic [2:0] l,
                          int ncyc, int stop_at, output int vcnt, output logic [2:0] end_sel);
    exp_t e;
    logic [2:0] held;
    held = '0;
    vcnt = 0;
    start_scan(m, d, f, l);
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      if (stop_at >= 0 && t == stop_at + 1) begin
        e.sel = held; e.valid = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.wrap = 1'b0;
      end else begin
        e = model(m, d, f, l, t);
      end
      chk_out(tag, e);
      if (sel_valid) vcnt++;
      end_sel = sel_out;
      if (t == stop_at) begin
        held = e.sel;
        stop = 1'b1;
      end
      step_clk();
      stop = 1'b0;
      if (stop_at >= 0 && t == stop_at + 1) break;
    end
  endtask

  vec_t vecs[6];

  initial begin
    int vcnt;
    logic [2:0] es;
    exp_t e;

    vecs[0] = '{2'b00, 1, 3'd0, 3'd7, 18, -1, 16, 3'd7};
    vecs[1] = '{2'b01, 0, 3'd1, 3'd6,  6, -1,  4, 3'd6};
    vecs[2] = '{2'b10, 0, 3'd2, 3'd4,  6,  4,  5, 3'd3};
    vecs[3] = '{2'b00, 2, 3'd6, 3'd1, 14, -1, 12, 3'd1};
    vecs[4] = '{2'b11, 1, 3'd3, 3'd3,  8,  6,  7, 3'd3};
    vecs[5] = '{2'b01, 0, 3'd0, 3'd5,  6, -1,  4, 3'd5};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    mode = '0; dwell = '0; first_sel = '0; last_sel = '0;
    #12;
    @(negedge clk);
    e = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    chk_out("reset", e);
    rst_n = 1'b1;
    step_clk();

    // Stop in IDLE is ignored.
    stop = 1'b1;
    step_clk();
    stop = 1'b0;
    @(negedge clk);
    chk_out("idle_stop", e);
    step_clk();

    foreach (vecs[i]) begin
      run_scan($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].f, vecs[i].l,
               vecs[i].ncyc, vecs[i].stop_at, vcnt, es);
      chk($sformatf("vec%0d.valid_cycles", i), vcnt, vecs[i].exp_valid_cycles);
      chk($sformatf("vec%0d.end_sel", i), int'(es), int'(vecs[i].exp_end_sel));
    end

    // Start while busy is ignored; start during the done cycle is accepted.
    start_scan(2'b00, 3, 3'd5, 3'd5);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk_out("busy_start", model(2'b00, 3, 3'd5, 3'd5, t));
      if (t == 1) begin
        first_sel = 3'd0; mode = 2'b00; start = 1'b1;
      end
      if (t == 4) begin
        mode = 2'b00; dwell = 8'd0; first_sel = 3'd0; last_sel = 3'd2; start = 1'b1;
      end
      step_clk();
      start = 1'b0;
    end
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk_out("done_restart", model(2'b00, 0, 3'd0, 3'd2, t));
      step_clk();
    end

    // Start and stop together in IDLE: start wins.
    stop = 1'b1;
    start_scan(2'b00, 0, 3'd4, 3'd5);
    stop = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk_out("start_stop", model(2'b00, 0, 3'd4, 3'd5, t));
      step_clk();
    end

    // Asynchronous reset in mid-cycle, then a clean re-run.
    start_scan(2'b00, 2, 3'd1, 3'd6);
    step_clk();
    step_clk();
    #1;
    rst_n = 1'b0;
    #1;
    e = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    chk_out("async_rst", e);
    #3;
    rst_n = 1'b1;
    step_clk();
    run_scan("after_rst", 2'b00, 2, 3'd1, 3'd6, 20, -1, vcnt, es);
    chk("after_rst.valid_cycles", vcnt, 18);

    // Randomized scans against the reference.
    for (int r = 0; r < 25; r++) begin
      logic [1:0] m;
      int d, len, sa, nc;
      logic [2:0] f, l;
      m = 2'($urandom);
      d = int'($urandom_range(0, 3));
      f = 3'($urandom);
      l = 3'($urandom);
      len = m[0] ? ((int'(f) - int'(l)) & 7) + 1 : ((int'(l) - int'(f)) & 7) + 1;
      if (m[1]) begin
        sa = int'($urandom_range(3, 30));
        nc = sa + 2;
      end else begin
        nc = len * (d + 1) + 2;
        sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len * (d + 1) - 1)) : -1;
      end
      run_scan($sformatf("rand%0d", r), m, d, f, l, nc, sa, vcnt, es);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
